mem_access_unit: RTL and testbench

Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB pipeline register. It converts a load/store from EX/MEM into a request/response transaction on the data-RAM port. It aligns and extends load data into the MEM/WB `in_ram_data` input, and drives the MEM/WB write enable. Multi-cycle RAM latency becomes a pipeline stall: upstream stages freeze and MEM/WB captures exactly once per instruction.

---
 rtl/mem_access_pkg.sv | 30 +++
 rtl/load_store_align.sv | 74 +++++++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage access controller.
//   mem_state_t : access FSM states
//   F3_*        : funct3 encodings for access size / signedness
//   f3_legal    : whether a funct3 code is meaningful for a load or a store
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants; loads accept all five encodings.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational data path for the memory stage.
//   Fault detection and store encoding work on the live EX/MEM fields;
//   load extraction works on the funct3/lane latched when the request was issued.
// Ports:
//   mem_read_i, mem_write_i, funct3_i, addr_lo_i, store_data_i : live instruction fields
//   ld_funct3_i, ld_lane_i, ld_word_i                          : latched load info + raw RAM word
//   fault_o    : access is misaligned or illegal
//   st_wdata_o : lane-replicated store data
//   st_be_o    : store byte enables
//   ld_data_o  : aligned, extended load result
module load_store_align
  import mem_access_pkg::*;
(
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lane_i,
  input  logic [31:0] ld_word_i,
  output logic        fault_o,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);

  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misaligned = 1'b0;
    if ((funct3_i == F3_H || funct3_i == F3_HU) && addr_lo_i[0]) begin
      misaligned = 1'b1;
    end
    if (funct3_i == F3_W && addr_lo_i != 2'b00) begin
      misaligned = 1'b1;
    end
    fault_o = (mem_read_i && mem_write_i)
           || !f3_legal(funct3_i, mem_write_i)
           || misaligned;
  end

  always_comb begin
    case (funct3_i)
      F3_B: begin
        st_wdata_o = {4{store_data_i[7:0]}};
        st_be_o    = 4'b0001 << addr_lo_i;
      end
      F3_H: begin
        st_wdata_o = {2{store_data_i[15:0]}};
        st_be_o    = 4'b0011 << addr_lo_i;
      end
      default: begin
        st_wdata_o = store_data_i;
        st_be_o    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_word_i[{ld_lane_i, 3'b000} +: 8];
    ld_half = ld_lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h000000, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0000, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller between EX/MEM and MEM/WB.
// Turns a load/store into one request/response transaction on the data-RAM
// port, stalls the upstream pipeline while the RAM is busy, and lets MEM/WB
// capture exactly once per instruction.
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   in_*                      : EX/MEM instruction fields
//   ram_req_*                 : RAM request channel (valid/ready)
//   ram_resp_valid/_data      : RAM load response (one-cycle pulse)
//   ram_data                  : aligned load result to MEM/WB
//   mem_wb_write_enable       : MEM/WB capture enable
//   stall                     : freeze PC, IF/ID, ID/EX, EX/MEM
//   access_fault              : one-cycle pulse on misaligned/illegal access
//
// state | meaning
// IDLE  | new instruction visible; legal memop issues, faulting memop skips to DONE
// REQ   | request on the RAM port, waiting for ready
// WAIT  | load accepted, waiting for the response pulse
// DONE  | result ready; pipeline advances this cycle
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_address,
  input  logic [31:0]           in_store_data,
  output logic                  ram_req_valid,
  input  logic                  ram_req_ready,
  output logic                  ram_req_write,
  output logic [ADDR_WIDTH-1:0] ram_req_address,
  output logic [31:0]           ram_req_wdata,
  output logic [3:0]            ram_req_byte_enable,
  input  logic                  ram_resp_valid,
  input  logic [31:0]           ram_resp_data,
  output logic [31:0]           ram_data,
  output logic                  mem_wb_write_enable,
  output logic                  stall,
  output logic                  access_fault
);

  mem_state_t            state_q, state_d;
  logic                  req_write_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [31:0]           req_wdata_q;
  logic [3:0]            req_be_q;
  logic [2:0]            ld_funct3_q;
  logic [1:0]            ld_lane_q;
  logic [31:0]           ram_data_q, ram_data_d;
  logic                  access_fault_q, access_fault_d;

  logic                  memop;
  logic                  fault;
  logic                  start_req;
  logic                  start_fault;
  logic                  load_done;
  logic [31:0]           st_wdata;
  logic [3:0]            st_be;
  logic [31:0]           ld_data;

  assign memop = in_valid && (in_mem_read || in_mem_write);

  load_store_align u_align (
    .mem_read_i   (in_mem_read),
    .mem_write_i  (in_mem_write),
    .funct3_i     (in_funct3),
    .addr_lo_i    (in_address[1:0]),
    .store_data_i (in_store_data),
    .ld_funct3_i  (ld_funct3_q),
    .ld_lane_i    (ld_lane_q),
    .ld_word_i    (ram_resp_data),
    .fault_o      (fault),
    .st_wdata_o   (st_wdata),
    .st_be_o      (st_be),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    start_req   = 1'b0;
    start_fault = 1'b0;
    load_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          if (fault) begin
            start_fault = 1'b1;
            state_d     = DONE;
          end else begin
            start_req = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (ram_req_ready) begin
          state_d = req_write_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (ram_resp_valid) begin
          load_done = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ram_data_d = ram_data_q;
    if (start_fault) begin
      ram_data_d = 32'h0000_0000;
    end else if (load_done) begin
      ram_data_d = ld_data;
    end
    access_fault_d = start_fault;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= 32'h0000_0000;
      req_be_q       <= 4'b0000;
      ld_funct3_q    <= 3'b000;
      ld_lane_q      <= 2'b00;
      ram_data_q     <= 32'h0000_0000;
      access_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ram_data_q     <= ram_data_d;
      access_fault_q <= access_fault_d;
      // Request fields are captured once so they stay stable for the whole
      // REQ phase regardless of what the live inputs do.
      if (start_req) begin
        req_write_q <= in_mem_write;
        req_addr_q  <= {in_address[ADDR_WIDTH-1:2], 2'b00};
        req_wdata_q <= in_mem_write ? st_wdata : 32'h0000_0000;
        req_be_q    <= in_mem_write ? st_be : 4'b0000;
        ld_funct3_q <= in_funct3;
        ld_lane_q   <= in_address[1:0];
      end
    end
  end

  assign stall               = memop && (state_q != DONE);
  assign mem_wb_write_enable = !stall;
  assign ram_req_valid       = (state_q == REQ);
  assign ram_req_write       = req_write_q;
  assign ram_req_address     = req_addr_q;
  assign ram_req_wdata       = req_wdata_q;
  assign ram_req_byte_enable = req_be_q;
  assign ram_data            = ram_data_q;
  assign access_fault        = access_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_mem_read, in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_address, in_store_data;
  logic        ram_req_valid, ram_req_ready, ram_req_write;
  logic [31:0] ram_req_address, ram_req_wdata;
  logic [3:0]  ram_req_byte_enable;
  logic        ram_resp_valid;
  logic [31:0] ram_resp_data, ram_data;
  logic        mem_wb_write_enable, stall, access_fault;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_valid            (in_valid),
    .in_mem_read         (in_mem_read),
    .in_mem_write        (in_mem_write),
    .in_funct3           (in_funct3),
    .in_address          (in_address),
    .in_store_data       (in_store_data),
    .ram_req_valid       (ram_req_valid),
    .ram_req_ready       (ram_req_ready),
    .ram_req_write       (ram_req_write),
    .ram_req_address     (ram_req_address),
    .ram_req_wdata       (ram_req_wdata),
    .ram_req_byte_enable (ram_req_byte_enable),
    .ram_resp_valid      (ram_resp_valid),
    .ram_resp_data       (ram_resp_data),
    .ram_data            (ram_data),
    .mem_wb_write_enable (mem_wb_write_enable),
    .stall               (stall),
    .access_fault        (access_fault)
  );

  typedef struct {
    bit          skip;
    bit          stall;
    bit          we;
    bit          rv;
    bit          fault;
    logic [31:0] rdata;
    bit          chk_fields;
    bit          chk_wd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mdl_rdata = 32'h0;
  int          exp_accepts = 0;
  int          seen_accepts = 0;
  int          stall_cyc = 0;
  int          fault_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit mdl_fault(input bit r, input bit w, input logic [2:0] f3,
                                   input logic [1:0] lo);
    bit legal;
    if (r && w) return 1'b1;
    if (w) legal = (f3 <= 3'd2);
    else   legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && lo[0]) return 1'b1;
    if (f3 == 3'd2 && lo != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [31:0] v;
    int unsigned sh;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      sh = 8 * int'(lane);
      v  = (word >> sh) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      sh = lane[1] ? 16 : 0;
      v  = (word >> sh) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [2:0] f3, input logic [1:0] lane);
    int unsigned m;
    if (f3 == 3'd0) m = 1 << lane;
    else if (f3 == 3'd1) m = 3 << lane;
    else m = 15;
    return 4'(m);
  endfunction

  function automatic exp_t mk(input bit s, input bit we, input bit rv, input bit f);
    exp_t e;
    e.skip = 1'b0; e.stall = s; e.we = we; e.rv = rv; e.fault = f;
    e.rdata = mdl_rdata; e.chk_fields = 1'b0; e.chk_wd = 1'b0; e.wr = 1'b0;
    e.addr = 32'h0; e.wdata = 32'h0; e.be = 4'h0;
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      cur = expq.pop_front();
      if (!cur.skip) begin
        chk("stall", 32'(stall), 32'(cur.stall));
        chk("mem_wb_we", 32'(mem_wb_write_enable), 32'(cur.we));
        chk("req_valid", 32'(ram_req_valid), 32'(cur.rv));
        chk("access_fault", 32'(access_fault), 32'(cur.fault));
        chk("ram_data", ram_data, cur.rdata);
        if (cur.chk_fields) begin
          chk("req_write", 32'(ram_req_write), 32'(cur.wr));
          chk("req_address", ram_req_address, cur.addr);
          chk("req_be", 32'(ram_req_byte_enable), 32'(cur.be));
          if (cur.chk_wd) chk("req_wdata", ram_req_wdata, cur.wdata);
        end
      end
    end
    if (stall) stall_cyc++;
    if (access_fault) fault_cyc++;
    if (ram_req_valid && ram_req_ready) seen_accepts++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // One instruction, with a planned RAM behaviour: rdy_dly cycles of ready=0
  // before acceptance, rsp_dly idle cycles in WAIT before the response.
  task automatic do_op(input bit v, input bit r, input bit w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] word);
    exp_t e;
    tick();
    in_valid = v; in_mem_read = r; in_mem_write = w; in_funct3 = f3;
    in_address = a; in_store_data = sd;
    ram_req_ready = 1'b0; ram_resp_valid = 1'b0;
    if (!(v && (r || w))) begin
      ram_req_ready  = 1'($urandom_range(0, 1));
      ram_resp_valid = ($urandom_range(0, 3) == 0);
      ram_resp_data  = $urandom;
      expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      return;
    end
    if (mdl_fault(r, w, f3, a[1:0])) begin
      expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
      mdl_rdata = 32'h0;
      tick();
      expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1));
      return;
    end
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i <= rdy_dly; i++) begin
      tick();
      ram_req_ready = (i == rdy_dly);
      e = mk(1'b1, 1'b0, 1'b1, 1'b0);
      e.chk_fields = 1'b1;
      e.wr = w;
      e.addr = a & 32'hFFFF_FFFC;
      e.be = w ? mdl_be(f3, a[1:0]) : 4'h0;
      e.chk_wd = w;
      e.wdata = mdl_wdata(f3, sd);
      expq.push_back(e);
    end
    exp_accepts++;
    if (!w) begin
      for (int i = 0; i <= rsp_dly; i++) begin
        tick();
        ram_req_ready  = 1'b0;
        ram_resp_valid = (i == rsp_dly);
        ram_resp_data  = (i == rsp_dly) ? word : $urandom;
        expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
      end
      mdl_rdata = mdl_load(f3, a[1:0], word);
    end
    tick();
    ram_req_ready = 1'b0; ram_resp_valid = 1'b0;
    expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic nonmem();
    do_op(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int s0, a0, f0;
    bit v, r, w;
    int kind;
    logic [2:0]  f3;
    logic [31:0] a;

    reset_n = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_funct3 = 3'd0; in_address = 32'h0; in_store_data = 32'h0;
    ram_req_ready = 1'b0; ram_resp_valid = 1'b0; ram_resp_data = 32'h0;
    repeat (2) @(posedge clk);

    // reset state
    tick();
    e = mk(1'b0, 1'b1, 1'b0, 1'b0);
    e.chk_fields = 1'b1; e.chk_wd = 1'b1;
    expq.push_back(e);
    // memop while reset is held: state stays IDLE, stall follows the rule
    tick();
    in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'd2;
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    in_valid = 1'b0; in_mem_read = 1'b0; reset_n = 1'b1;
    expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));

    // model pinned to hand-computed values
    chk("mdl_lb",  mdl_load(3'd0, 2'd3, 32'h80FF1234), 32'hFFFF_FF80);
    chk("mdl_lbu", mdl_load(3'd4, 2'd3, 32'h80FF1234), 32'h0000_0080);
    chk("mdl_lh",  mdl_load(3'd1, 2'd2, 32'h80FF1234), 32'hFFFF_80FF);
    chk("mdl_sb_wdata", mdl_wdata(3'd0, 32'h0000_00A5), 32'hA5A5_A5A5);
    chk("mdl_sb_be", 32'(mdl_be(3'd0, 2'd1)), 32'h2);

    // LW 0x100, minimum latency
    s0 = stall_cyc;
    do_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    nonmem(); settle();
    chk("lw_data", ram_data, 32'hDEAD_BEEF);
    chk("lw_stalls", 32'(stall_cyc - s0), 32'd3);

    // LB / LBU / LH
    do_op(1'b1, 1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);
    nonmem(); settle();
    chk("lb_data", ram_data, 32'hFFFF_FF80);
    do_op(1'b1, 1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);
    nonmem(); settle();
    chk("lbu_data", ram_data, 32'h0000_0080);
    do_op(1'b1, 1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 0, 0, 32'h80FF_1234);
    nonmem(); settle();
    chk("lh_data", ram_data, 32'hFFFF_80FF);

    // SB 0x201 with ready low for 2 cycles
    s0 = stall_cyc; a0 = seen_accepts;
    do_op(1'b1, 1'b0, 1'b1, 3'd0, 32'h201, 32'h0000_00A5, 2, 0, 32'h0);
    nonmem(); settle();
    chk("sb_stalls", 32'(stall_cyc - s0), 32'd4);
    chk("sb_accepts", 32'(seen_accepts - a0), 32'd1);

    // misaligned LW
    s0 = stall_cyc; a0 = seen_accepts; f0 = fault_cyc;
    do_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 0, 0, 32'h0);
    nonmem(); settle();
    chk("fault_stalls", 32'(stall_cyc - s0), 32'd1);
    chk("fault_accepts", 32'(seen_accepts - a0), 32'd0);
    chk("fault_pulses", 32'(fault_cyc - f0), 32'd1);
    chk("fault_data", ram_data, 32'h0);

    // non-memory stream
    s0 = stall_cyc; a0 = seen_accepts;
    for (int i = 0; i < 8; i++) begin
      v = 1'($urandom_range(0, 1));
      do_op(v, v ? 1'b0 : 1'($urandom_range(0, 1)), v ? 1'b0 : 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), $urandom, $urandom, 0, 0, 32'h0);
    end
    settle();
    chk("nonmem_stalls", 32'(stall_cyc - s0), 32'd0);

    // reset while a load waits, then a late response
    do_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 0, 0, 32'h1122_3344);
    tick();
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'd2;
    in_address = 32'h300;
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    ram_req_ready = 1'b1;
    e = mk(1'b1, 1'b0, 1'b1, 1'b0);
    e.chk_fields = 1'b1; e.addr = 32'h300;
    expq.push_back(e);
    exp_accepts++;
    tick();
    ram_req_ready = 1'b0;
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    reset_n = 1'b0; in_valid = 1'b0;
    e = mk(1'b0, 1'b0, 1'b0, 1'b0);
    e.skip = 1'b1;
    expq.push_back(e);
    tick();
    reset_n = 1'b1; ram_resp_valid = 1'b1; ram_resp_data = 32'hCAFE_F00D;
    mdl_rdata = 32'h0;
    expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
    settle();
    chk("rst_data", ram_data, 32'h0);
    chk("rst_req_valid", 32'(ram_req_valid), 32'd0);
    do_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 0, 1, 32'h1357_9BDF);
    nonmem(); settle();
    chk("post_rst_lw", ram_data, 32'h1357_9BDF);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      v = 1'b1; r = 1'b0; w = 1'b0;
      if (kind < 3) begin
        v = 1'($urandom_range(0, 1));
        if (!v) begin
          r = 1'($urandom_range(0, 1));
          w = 1'($urandom_range(0, 1));
        end
      end else if (kind < 6) begin
        r = 1'b1;
      end else if (kind < 9) begin
        w = 1'b1;
      end else begin
        r = 1'b1; w = 1'b1;
      end
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_op(v, r, w, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    nonmem(); settle();
    chk("total_accepts", 32'(seen_accepts), 32'(exp_accepts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
